biquad_cascade_tdm: RTL and testbench
=====================================

BIQUAD_CASCADE_TDM -- requirements
Module: biquad_cascade_tdm

Interface
REQ-001 The block SHALL be parametrised as follows (name, default, meaning):
  - Width, 23: sample and coefficient word width, two's complement.
  - Presicion, 14: number of fractional bits.
  - NSEC, 2: number of cascaded biquad sections, range 1..8.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The ports SHALL be (name, direction, width, meaning):
  - clock, in, 1: rising-edge clock.
  - reset, in, 1: asynchronous active-low reset.
  - clear, in, 1: synchronous zeroing of all section state.
  - uk, in, Width: input sample.
  - in_valid, in, 1: uk is valid.
  - in_ready, out, 1: block can accept a sample.
  - yk, out, Width: filter output.
  - out_valid, out, 1: yk is valid.
  - out_ready, in, 1: consumer accepts yk.
  - coef_we, in, 1: coefficient write strobe.
  - coef_sec, in, 3: target section index.
  - coef_sel, in, 3: target coefficient; 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
  - coef_data, in, Width: coefficient value.
  - coef_err, out, 1: one-cycle pulse on a rejected write.
  - sat_flag, out, 1: sticky saturation indicator.

Function
REQ-004 Each section s SHALL compute the following, where the a coefficients carry their own sign:
  - fk = sat(x_s + a1*w1 + a2*w2)
  - y_s = sat(b0*fk + b1*w1 + b2*w2)
  - then w2<=w1 and w1<=fk.
  - x_0 = uk; x_(s+1) = y_s; yk = y_(NSEC-1).
REQ-005 The block SHALL use exactly one Width x Width signed multiplier, time-multiplexed across all products.
REQ-006 Products SHALL be accumulated at full precision in an accumulator of at least 2*Width+3 bits. The sum SHALL be arithmetic-shifted right by Presicion (truncation toward minus infinity) before addition of x_s and before saturation.
REQ-007 sat() SHALL clamp to the range [-2^(Width-1), 2^(Width-1)-1]. Any clamp event SHALL set sat_flag; sat_flag clears only on reset or clear.
REQ-008 The FSM SHALL have states IDLE, MAC, OUT.
REQ-009 In IDLE, in_ready=1. The edge with in_valid&in_ready accepts uk and moves to MAC with section=0, phase=0.
REQ-010 In MAC, each section SHALL take 5 cycles:
  - phase 0: acc=a1*w1
  - phase 1: acc+=a2*w2
  - phase 2: fk latched, acc=b0*fk
  - phase 3: acc+=b1*w1
  - phase 4: acc+=b2*w2, y_s latched, state shifted
  After phase 4 the FSM SHALL advance to the next section, or to OUT after section NSEC-1.
REQ-011 out_valid SHALL rise exactly 5*NSEC+1 edges after the accepting edge, with in_ready=0 throughout MAC and OUT.
REQ-012 In OUT, yk and out_valid SHALL hold stable until out_valid&out_ready. The FSM SHALL then return to IDLE, with in_ready=1 on the following cycle.
REQ-013 A coef_we edge in IDLE SHALL write coef_data to the addressed register.
REQ-014 A coef_we edge in MAC or OUT, or with coef_sec>=NSEC, or with coef_sel>4, SHALL be dropped with no register change, and SHALL pulse coef_err for one cycle.
REQ-015 clear in IDLE or OUT SHALL zero all w1/w2, the accumulator and sat_flag on the next edge; coefficients and yk SHALL be kept.
REQ-016 clear in MAC SHALL abort the computation: zero state, return to IDLE, and assert no out_valid.
REQ-017 in_valid held while in_ready=0 SHALL NOT be accepted; the sample SHALL be taken only on a later IDLE edge.

Reset
REQ-018 On reset=0, the following SHALL be zero asynchronously: FSM (to IDLE), accumulator, all w1/w2, all coefficients, yk, out_valid, coef_err and sat_flag; in_ready SHALL be 1.
REQ-019 Reset asserted mid-MAC SHALL discard the sample; no out_valid SHALL follow after reset deasserts.

Verification
REQ-020 NSEC=1; b0=8192, b1=8192, a1=8192, others 0; input 16384, 0, 0 -> yk = 8192, 12288, 6144; each out_valid 6 edges after acceptance.
REQ-021 NSEC=2; both sections b0=16384, others 0; input 1000 -> yk=1000 at 11 edges after acceptance; sat_flag=0.
REQ-022 b0=32767 (~2.0); input 2^21 -> yk=4194303; sat_flag=1 and stays 1 until clear.
REQ-023 out_ready=0 for 20 cycles after out_valid:
  - yk remains stable and in_ready=0 throughout.
  - A pending in_valid is accepted only after the out_ready handshake.
REQ-024 coef_we during MAC -> coef_err pulses once, the coefficient is unchanged, and the next sample uses the old value.
REQ-025 reset pulsed at MAC phase 3 -> all outputs are 0 and in_ready=1; a subsequent impulse gives the REQ-020 response only after coefficients are rewritten.

Source files
------------

// File: rtl/biquad_cascade_tdm.sv
// Purpose: cascade of NSEC direct-form-II biquads sharing one signed multiplier.
// Latency: out_valid rises 5*NSEC+1 edges after the edge that accepts uk.
// Backpressure: one sample in flight; in_ready is low from acceptance until yk handshakes.
// Ports: clock / reset (async, active-low); clear zeroes section state synchronously;
//   uk/in_valid/in_ready input stream; yk/out_valid/out_ready output stream;
//   coef_we/coef_sec/coef_sel/coef_data coefficient write port (IDLE only), coef_err
//   pulses on a rejected write; sat_flag is a sticky clamp indicator.
module biquad_cascade_tdm #(
  parameter int Width     = 23,
  parameter int Presicion = 14,
  parameter int NSEC      = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic signed [Width-1:0] uk,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [Width-1:0] yk,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    coef_we,
  input  logic [2:0]              coef_sec,
  input  logic [2:0]              coef_sel,
  input  logic signed [Width-1:0] coef_data,
  output logic                    coef_err,
  output logic                    sat_flag
);

  localparam int ACCW = 2*Width + 3;
  localparam int SECW = (NSEC > 1) ? $clog2(NSEC) : 1;
  // Clamp limits, sign-extended to the width of the pre-saturation sums.
  localparam logic signed [ACCW:0] SMAX = {{(ACCW+2-Width){1'b0}}, {(Width-1){1'b1}}};
  localparam logic signed [ACCW:0] SMIN = {{(ACCW+2-Width){1'b1}}, {(Width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                  state, state_nxt;
  logic [SECW-1:0]         sec;
  logic [2:0]              phase;
  logic                    last_sec;

  // coef[s][0..4] = b0, b1, b2, a1, a2
  logic signed [Width-1:0] coef [NSEC][5];
  logic signed [Width-1:0] w1 [NSEC];
  logic signed [Width-1:0] w2 [NSEC];
  logic signed [Width-1:0] x;     // input of the section being computed
  logic signed [Width-1:0] fk;    // feedback node of the current section
  logic signed [ACCW-1:0]  acc;

  logic signed [Width-1:0]   w1_s, w2_s;
  logic signed [Width-1:0]   mul_a, mul_b;
  logic signed [2*Width-1:0] prod;
  logic signed [ACCW-1:0]    acc_sh, acc_base, acc_nxt, ysh;
  logic signed [ACCW:0]      fsum, ysum;
  logic signed [Width-1:0]   fk_new, y_new;
  logic                      clamp_f, clamp_y;
  logic                      coef_addr_ok, coef_wr_ok;

  function automatic logic signed [Width-1:0] sat_w(input logic signed [ACCW:0] v);
    if (v > SMAX)      sat_w = SMAX[Width-1:0];
    else if (v < SMIN) sat_w = SMIN[Width-1:0];
    else               sat_w = v[Width-1:0];
  endfunction

  function automatic logic clips(input logic signed [ACCW:0] v);
    clips = (v > SMAX) || (v < SMIN);
  endfunction

  assign last_sec     = (sec == SECW'(NSEC-1));
  assign coef_addr_ok = (int'(coef_sec) < NSEC) && (coef_sel <= 3'd4);
  assign coef_wr_ok   = (state == IDLE) && coef_addr_ok;

  // Datapath: one multiplier whose operands are steered by phase.
  always_comb begin
    w1_s   = w1[sec];
    w2_s   = w2[sec];
    acc_sh = acc >>> Presicion;
    // fk uses the accumulated feedback products (phases 0..1) plus x.
    fsum    = $signed({{(ACCW+1-Width){x[Width-1]}}, x}) + $signed({acc_sh[ACCW-1], acc_sh});
    fk_new  = sat_w(fsum);
    clamp_f = clips(fsum);
    mul_a = '0;
    mul_b = '0;
    case (phase)
      3'd0: begin mul_a = coef[sec][3]; mul_b = w1_s;   end
      3'd1: begin mul_a = coef[sec][4]; mul_b = w2_s;   end
      3'd2: begin mul_a = coef[sec][0]; mul_b = fk_new; end
      3'd3: begin mul_a = coef[sec][1]; mul_b = w1_s;   end
      3'd4: begin mul_a = coef[sec][2]; mul_b = w2_s;   end
      default: ;
    endcase
    prod     = (2*Width)'(mul_a) * (2*Width)'(mul_b);
    // Phases 0 and 2 start a fresh sum.
    acc_base = (phase == 3'd0 || phase == 3'd2) ? '0 : acc;
    acc_nxt  = acc_base + $signed({{(ACCW-2*Width){prod[2*Width-1]}}, prod});
    ysh      = acc_nxt >>> Presicion;
    ysum     = $signed({ysh[ACCW-1], ysh});
    y_new    = sat_w(ysum);
    clamp_y  = clips(ysum);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MAC;
      end
      MAC: begin
        if (clear)                           state_nxt = IDLE;
        else if (phase == 3'd4 && last_sec)  state_nxt = OUT;
      end
      OUT: begin
        if (out_valid && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sec       <= '0;
      phase     <= '0;
      x         <= '0;
      fk        <= '0;
      acc       <= '0;
      yk        <= '0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      sat_flag  <= 1'b0;
      for (int s = 0; s < NSEC; s++) begin
        w1[s] <= '0;
        w2[s] <= '0;
        for (int c = 0; c < 5; c++) coef[s][c] <= '0;
      end
    end else begin
      coef_err <= coef_we && !coef_wr_ok;
      if (coef_we && coef_wr_ok) coef[coef_sec[SECW-1:0]][coef_sel] <= coef_data;

      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= uk;
            sec   <= '0;
            phase <= '0;
          end
        end
        MAC: begin
          if (!clear) begin
            acc <= acc_nxt;
            if (phase == 3'd2) begin
              fk <= fk_new;
              if (clamp_f) sat_flag <= 1'b1;
            end
            if (phase == 3'd4) begin
              w2[sec] <= w1_s;
              w1[sec] <= fk;
              x       <= y_new;
              phase   <= '0;
              if (!last_sec) sec <= sec + SECW'(1);
              if (clamp_y) sat_flag <= 1'b1;
            end else begin
              phase <= phase + 3'd1;
            end
          end
        end
        OUT: begin
          // First OUT cycle publishes the result; it then holds until taken.
          if (!out_valid) begin
            yk        <= x;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      if (clear) begin
        acc      <= '0;
        sat_flag <= 1'b0;
        for (int s = 0; s < NSEC; s++) begin
          w1[s] <= '0;
          w2[s] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_biquad_cascade_tdm.sv
// Purpose: self-checking bench for biquad_cascade_tdm against a per-sample arithmetic model.
// Latency: drives on negedges, samples on negedges; results expected 5*N+1 edges after accept.
// Backpressure: exercises held out_ready=0 with a pending in_valid.
module tb_biquad_cascade_tdm;

  localparam int     W    = 23;
  localparam int     P    = 14;
  localparam int     N    = 2;
  localparam int     LAT  = 5*N + 1;
  localparam longint YMAX = (longint'(1) <<< (W-1)) - 1;
  localparam longint YMIN = -(longint'(1) <<< (W-1));

  logic                clock = 1'b0;
  logic                reset, clear, in_valid, out_ready, coef_we;
  logic signed [W-1:0] uk, coef_data;
  logic [2:0]          coef_sec, coef_sel;
  logic                in_ready, out_valid, coef_err, sat_flag;
  logic signed [W-1:0] yk;

  int nvec = 0;
  int nerr = 0;

  biquad_cascade_tdm #(.Width(W), .Presicion(P), .NSEC(N)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .uk(uk), .in_valid(in_valid), .in_ready(in_ready),
    .yk(yk), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_sec(coef_sec), .coef_sel(coef_sel), .coef_data(coef_data),
    .coef_err(coef_err), .sat_flag(sat_flag)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: coefficients, per-section w1/w2 ----------------
  longint m_c  [N][5];
  longint m_w1 [N];
  longint m_w2 [N];
  bit     m_sat;

  function automatic longint m_clip(input longint v);
    if (v > YMAX) begin m_sat = 1'b1; return YMAX; end
    if (v < YMIN) begin m_sat = 1'b1; return YMIN; end
    return v;
  endfunction

  function automatic longint m_step(input longint u);
    longint xs, a, f, y;
    xs = u;
    for (int s = 0; s < N; s++) begin
      a = m_c[s][3]*m_w1[s] + m_c[s][4]*m_w2[s];
      f = m_clip(xs + (a >>> P));
      a = m_c[s][0]*f + m_c[s][1]*m_w1[s] + m_c[s][2]*m_w2[s];
      y = m_clip(a >>> P);
      m_w2[s] = m_w1[s];
      m_w1[s] = f;
      xs = y;
    end
    return xs;
  endfunction

  function automatic void m_zero_state();
    for (int s = 0; s < N; s++) begin m_w1[s] = 0; m_w2[s] = 0; end
    m_sat = 1'b0;
  endfunction

  function automatic void m_reset_all();
    m_zero_state();
    for (int s = 0; s < N; s++) for (int c = 0; c < 5; c++) m_c[s][c] = 0;
  endfunction

  // ---------------- stimulus helpers (all start and end at a negedge) ----------------
  task automatic put_coef(input int s, input int sel, input longint v);
    coef_sec  = s[2:0];
    coef_sel  = sel[2:0];
    coef_data = v[W-1:0];
    coef_we   = 1'b1;
    @(negedge clock);
    coef_we = 1'b0;
    if (s < N && sel <= 4) m_c[s][sel] = v;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    m_zero_state();
  endtask

  task automatic accept(input longint v);
    int t;
    uk = v[W-1:0];
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 100) begin @(negedge clock); t++; end
    if (t >= 100) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n0, output int lat, output bit rbad);
    int n;
    n = n0;
    rbad = 1'b0;
    while (out_valid !== 1'b1 && n < 200) begin
      if (in_ready !== 1'b0) rbad = 1'b1;
      @(negedge clock);
      n++;
    end
    if (in_ready !== 1'b0) rbad = 1'b1;
    lat = n;
    if (n >= 200) begin
      nvec++; nerr++;
      $display("FAIL out_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic run_sample(input longint v, input int d, output longint y, output int lat,
                            output bit rbad);
    accept(v);
    wait_out(0, lat, rbad);
    y = yk;
    repeat (d) @(negedge clock);
    handshake();
  endtask

  task automatic load_impulse_coefs();
    put_coef(0, 0, 8192); put_coef(0, 1, 8192); put_coef(0, 2, 0);
    put_coef(0, 3, 8192); put_coef(0, 4, 0);
    put_coef(1, 0, 16384); put_coef(1, 1, 0); put_coef(1, 2, 0);
    put_coef(1, 3, 0);     put_coef(1, 4, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nvec++; if (yk !== 0) begin nerr++; $display("FAIL reset_yk: got %0d want 0", yk); end
    nvec++; if (sat_flag !== 1'b0) begin nerr++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
    nvec++; if (coef_err !== 1'b0) begin nerr++; $display("FAIL reset_coef_err: got %b want 0", coef_err); end
    reset = 1'b1;
    m_reset_all();
    @(negedge clock);
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic check_impulse_response(input string tag);
    longint stim  [3] = '{16384, 0, 0};
    longint exp_y [3] = '{8192, 12288, 6144};
    longint y, e;
    int     lat;
    bit     rbad;
    for (int i = 0; i < 3; i++) begin
      run_sample(stim[i], 0, y, lat, rbad);
      e = m_step(stim[i]);
      nvec++; if (y !== exp_y[i]) begin nerr++; $display("FAIL %s_y%0d: got %0d want %0d", tag, i, y, exp_y[i]); end
      nvec++; if (y !== e) begin nerr++; $display("FAIL %s_model%0d: got %0d want %0d", tag, i, y, e); end
      nvec++; if (lat !== LAT) begin nerr++; $display("FAIL %s_latency%0d: got %0d want %0d", tag, i, lat, LAT); end
      nvec++; if (rbad !== 1'b0) begin nerr++; $display("FAIL %s_in_ready_busy%0d: got high want low", tag, i); end
    end
  endtask

  task automatic test_impulse();
    load_impulse_coefs();
    do_clear();
    check_impulse_response("impulse");
  endtask

  task automatic test_unity();
    longint y, e;
    int     lat;
    bit     rbad;
    for (int s = 0; s < N; s++) for (int c = 0; c < 5; c++) put_coef(s, c, (c == 0) ? 16384 : 0);
    do_clear();
    run_sample(1000, 0, y, lat, rbad);
    e = m_step(1000);
    nvec++; if (y !== 1000) begin nerr++; $display("FAIL unity_y: got %0d want 1000", y); end
    nvec++; if (y !== e) begin nerr++; $display("FAIL unity_model: got %0d want %0d", y, e); end
    nvec++; if (lat !== LAT) begin nerr++; $display("FAIL unity_latency: got %0d want %0d", lat, LAT); end
    nvec++; if (sat_flag !== 1'b0) begin nerr++; $display("FAIL unity_sat_flag: got %b want 0", sat_flag); end
  endtask

  task automatic test_saturation();
    longint y, e;
    int     lat;
    bit     rbad;
    put_coef(0, 0, 32767);
    put_coef(1, 0, 32767);
    run_sample(longint'(1) <<< 21, 0, y, lat, rbad);
    e = m_step(longint'(1) <<< 21);
    nvec++; if (y !== 4194303) begin nerr++; $display("FAIL sat_y: got %0d want 4194303", y); end
    nvec++; if (y !== e) begin nerr++; $display("FAIL sat_model: got %0d want %0d", y, e); end
    nvec++; if (sat_flag !== 1'b1) begin nerr++; $display("FAIL sat_flag_set: got %b want 1", sat_flag); end
    run_sample(0, 2, y, lat, rbad);
    e = m_step(0);
    nvec++; if (y !== e) begin nerr++; $display("FAIL sat_next_y: got %0d want %0d", y, e); end
    nvec++; if (sat_flag !== 1'b1) begin nerr++; $display("FAIL sat_flag_sticky: got %b want 1", sat_flag); end
    do_clear();
    nvec++; if (sat_flag !== 1'b0) begin nerr++; $display("FAIL sat_flag_clear: got %b want 0", sat_flag); end
    nvec++; if (yk !== y) begin nerr++; $display("FAIL clear_keeps_yk: got %0d want %0d", yk, y); end
  endtask

  task automatic test_backpressure();
    longint ya, ea, y, e;
    int     lat;
    bit     rbad, bad;
    load_impulse_coefs();
    do_clear();
    accept(5000);
    wait_out(0, lat, rbad);
    ya = yk;
    ea = m_step(5000);
    nvec++; if (ya !== ea) begin nerr++; $display("FAIL bp_first_y: got %0d want %0d", ya, ea); end
    uk = -23'sd3000;
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (yk !== ya || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
      @(negedge clock);
    end
    nvec++; if (bad !== 1'b0) begin nerr++; $display("FAIL bp_hold: yk/out_valid/in_ready moved while stalled, yk=%0d want %0d", yk, ya); end
    handshake();
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_after_hs: got %b want 1", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_valid_after_hs: got %b want 0", out_valid); end
    @(negedge clock);
    in_valid = 1'b0;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_pending_taken: in_ready=%b want 0", in_ready); end
    wait_out(0, lat, rbad);
    y = yk;
    e = m_step(-3000);
    handshake();
    nvec++; if (y !== e) begin nerr++; $display("FAIL bp_second_y: got %0d want %0d", y, e); end
    nvec++; if (lat !== LAT) begin nerr++; $display("FAIL bp_second_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_coef_err();
    longint y, e;
    int     lat;
    bit     rbad;
    put_coef(N, 0, 1234);
    nvec++; if (coef_err !== 1'b1) begin nerr++; $display("FAIL cerr_bad_sec: got %b want 1", coef_err); end
    @(negedge clock);
    nvec++; if (coef_err !== 1'b0) begin nerr++; $display("FAIL cerr_one_pulse: got %b want 0", coef_err); end
    put_coef(0, 5, 999);
    nvec++; if (coef_err !== 1'b1) begin nerr++; $display("FAIL cerr_bad_sel: got %b want 1", coef_err); end
    put_coef(1, 1, 0);
    nvec++; if (coef_err !== 1'b0) begin nerr++; $display("FAIL cerr_legal: got %b want 0", coef_err); end
    accept(700);
    repeat (2) @(negedge clock);
    coef_sec = 3'd0; coef_sel = 3'd0; coef_data = 23'sd100; coef_we = 1'b1;
    @(negedge clock);
    coef_we = 1'b0;
    nvec++; if (coef_err !== 1'b1) begin nerr++; $display("FAIL cerr_mac: got %b want 1", coef_err); end
    @(negedge clock);
    nvec++; if (coef_err !== 1'b0) begin nerr++; $display("FAIL cerr_mac_pulse: got %b want 0", coef_err); end
    wait_out(4, lat, rbad);
    y = yk;
    e = m_step(700);
    handshake();
    nvec++; if (y !== e) begin nerr++; $display("FAIL cerr_mac_y: got %0d want %0d", y, e); end
    nvec++; if (lat !== LAT) begin nerr++; $display("FAIL cerr_mac_latency: got %0d want %0d", lat, LAT); end
    run_sample(-1200, 0, y, lat, rbad);
    e = m_step(-1200);
    nvec++; if (y !== e) begin nerr++; $display("FAIL cerr_next_y: got %0d want %0d", y, e); end
  endtask

  task automatic test_clear_mac();
    longint y, e;
    int     lat;
    bit     rbad, bad;
    accept(4321);
    repeat (2) @(negedge clock);
    do_clear();
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL clrmac_in_ready: got %b want 1", in_ready); end
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      @(negedge clock);
    end
    nvec++; if (bad !== 1'b0) begin nerr++; $display("FAIL clrmac_no_valid: out_valid seen 1, want 0"); end
    run_sample(2500, 1, y, lat, rbad);
    e = m_step(2500);
    nvec++; if (y !== e) begin nerr++; $display("FAIL clrmac_next_y: got %0d want %0d", y, e); end
  endtask

  task automatic test_reset_mid();
    longint y, e;
    int     lat;
    bit     rbad, bad;
    load_impulse_coefs();
    do_clear();
    accept(16384);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    nvec++; if (yk !== 0) begin nerr++; $display("FAIL rstmid_yk: got %0d want 0", yk); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    nvec++; if (sat_flag !== 1'b0 || coef_err !== 1'b0) begin nerr++; $display("FAIL rstmid_flags: got %b%b want 00", sat_flag, coef_err); end
    @(negedge clock);
    reset = 1'b1;
    m_reset_all();
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      @(negedge clock);
    end
    nvec++; if (bad !== 1'b0) begin nerr++; $display("FAIL rstmid_no_valid: out_valid seen 1, want 0"); end
    run_sample(16384, 0, y, lat, rbad);
    e = m_step(16384);
    nvec++; if (y !== 0) begin nerr++; $display("FAIL rstmid_zero_coef_y: got %0d want 0", y); end
    nvec++; if (y !== e) begin nerr++; $display("FAIL rstmid_zero_coef_model: got %0d want %0d", y, e); end
    do_clear();
    load_impulse_coefs();
    check_impulse_response("rstmid_reload");
  endtask

  task automatic test_random();
    longint v, y, e;
    int     lat;
    bit     rbad;
    do_clear();
    for (int blk = 0; blk < 3; blk++) begin
      for (int s = 0; s < N; s++) begin
        put_coef(s, 0, longint'($urandom_range(0, 32766)) - 16383);
        put_coef(s, 1, longint'($urandom_range(0, 32766)) - 16383);
        put_coef(s, 2, longint'($urandom_range(0, 32766)) - 16383);
        put_coef(s, 3, longint'($urandom_range(0, 24000)) - 12000);
        put_coef(s, 4, longint'($urandom_range(0, 12000)) - 6000);
      end
      for (int i = 0; i < 8; i++) begin
        v = longint'($urandom_range(0, 2097152)) - 1048576;
        repeat ($urandom_range(0, 2)) @(negedge clock);
        run_sample(v, int'($urandom_range(0, 3)), y, lat, rbad);
        e = m_step(v);
        nvec++; if (y !== e) begin nerr++; $display("FAIL rand_y b%0d s%0d: in %0d got %0d want %0d", blk, i, v, y, e); end
        nvec++; if (lat !== LAT) begin nerr++; $display("FAIL rand_latency b%0d s%0d: got %0d want %0d", blk, i, lat, LAT); end
        nvec++; if (sat_flag !== m_sat) begin nerr++; $display("FAIL rand_sat_flag b%0d s%0d: got %b want %b", blk, i, sat_flag, m_sat); end
      end
    end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; coef_we = 1'b0;
    uk = '0; coef_data = '0; coef_sec = '0; coef_sel = '0;
    m_reset_all();
    @(negedge clock);
    test_reset();
    test_impulse();
    test_unity();
    test_saturation();
    test_backpressure();
    test_coef_err();
    test_clear_mac();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
